// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its serial controller.
package usr_pkg;

  localparam logic [1:0] USR_HOLD  = 2'b00;
  localparam logic [1:0] USR_RIGHT = 2'b01;
  localparam logic [1:0] USR_LEFT  = 2'b10;
  localparam logic [1:0] USR_LOAD  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } usr_ctrl_state_t;

endpackage

// File: rtl/usr_serializer.sv
// Serializer wrapper: controller plus universal shift register.
// Exposes ser_ready when USR_CTRL_STALL_EN is defined.
module usr_serializer
  import usr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_dir,
  input  logic         in_fill,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         ser_bit,
  output logic         ser_valid,
`ifdef USR_CTRL_STALL_EN
  input  logic         ser_ready,
`endif
  output logic         done,
  output logic [N-1:0] q
);

  logic [1:0]   usr_s;
  logic [N-1:0] usr_I;
  logic         usr_MSB_in;
  logic         usr_LSB_in;

  usr_serial_ctrl #(.N(N)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_dir     (in_dir),
    .in_fill    (in_fill),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .usr_s      (usr_s),
    .usr_I      (usr_I),
    .usr_MSB_in (usr_MSB_in),
    .usr_LSB_in (usr_LSB_in),
    .usr_Q      (q),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
`ifdef USR_CTRL_STALL_EN
    .ser_ready  (ser_ready),
`endif
    .done       (done)
  );

  // Register uses an active-low reset.
  usr_shift_reg #(.N(N)) u_reg (
    .clk    (clk),
    .rst_b  (~reset),
    .s      (usr_s),
    .I      (usr_I),
    .MSB_in (usr_MSB_in),
    .LSB_in (usr_LSB_in),
    .Q      (q)
  );

endmodule

// File: rtl/usr_shift_reg.sv
// N-bit universal shift register: hold, shift right, shift left, parallel load.
module usr_shift_reg
  import usr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [1:0]   s,
  input  logic [N-1:0] I,
  input  logic         MSB_in,
  input  logic         LSB_in,
  output logic [N-1:0] Q
);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      Q <= '0;
    end else begin
      case (s)
        USR_RIGHT: Q <= {MSB_in, Q[N-1:1]};
        USR_LEFT:  Q <= {Q[N-2:0], LSB_in};
        USR_LOAD:  Q <= I;
        default:   Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/usr_serial_ctrl.sv
// Word-to-bit serializer controller driving a universal shift register.
// Optional consumer back-pressure via ser_ready when USR_CTRL_STALL_EN is defined.
//
// state | meaning
// IDLE  | ready for a word; load request forwarded to the register
// SHIFT | streaming the loaded word, one bit per accepted cycle
module usr_serial_ctrl
  import usr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_dir,
  input  logic         in_fill,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [1:0]   usr_s,
  output logic [N-1:0] usr_I,
  output logic         usr_MSB_in,
  output logic         usr_LSB_in,
  input  logic [N-1:0] usr_Q,
  output logic         ser_bit,
  output logic         ser_valid,
`ifdef USR_CTRL_STALL_EN
  input  logic         ser_ready,
`endif
  output logic         done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  usr_ctrl_state_t state;
  logic [CW-1:0]   cnt;
  logic            dir_q;
  logic            fill_q;
  logic            advance;
  logic [CW-1:0]   sel_idx;

`ifdef USR_CTRL_STALL_EN
  assign advance = (state == SHIFT) && ser_ready;
`else
  assign advance = (state == SHIFT);
`endif

  assign usr_I     = in_data;
  assign in_ready  = !reset && (state == IDLE);
  assign ser_valid = !reset && (state == SHIFT);
  assign sel_idx   = dir_q ? LAST : '0;
  assign ser_bit   = usr_Q[sel_idx];

  always_comb begin
    usr_s      = USR_HOLD;
    usr_MSB_in = 1'b0;
    usr_LSB_in = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        usr_s = in_valid ? USR_LOAD : USR_HOLD;
      end else if (advance) begin
        usr_s      = dir_q ? USR_LEFT : USR_RIGHT;
        usr_MSB_in = fill_q;
        usr_LSB_in = fill_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      dir_q  <= 1'b0;
      fill_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dir_q  <= in_dir;
            fill_q <= in_fill;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (advance) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usr_serial_ctrl.sv
// Self-checking bench for usr_serial_ctrl paired with usr_shift_reg (N=4).
// Stall scenario is built only when USR_CTRL_STALL_EN is defined.
module tb_usr_serial_ctrl;
  import usr_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] in_data;
  logic         in_dir;
  logic         in_fill;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   usr_s;
  logic [N-1:0] usr_I;
  logic         usr_MSB_in;
  logic         usr_LSB_in;
  logic [N-1:0] usr_Q;
  logic         ser_bit;
  logic         ser_valid;
  logic         done;
`ifdef USR_CTRL_STALL_EN
  logic         ser_ready;
`endif

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_done = 1'b0;

  always #5 clk = ~clk;

  usr_serial_ctrl #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_dir     (in_dir),
    .in_fill    (in_fill),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .usr_s      (usr_s),
    .usr_I      (usr_I),
    .usr_MSB_in (usr_MSB_in),
    .usr_LSB_in (usr_LSB_in),
    .usr_Q      (usr_Q),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
`ifdef USR_CTRL_STALL_EN
    .ser_ready  (ser_ready),
`endif
    .done       (done)
  );

  usr_shift_reg #(.N(N)) u_reg (
    .clk    (clk),
    .rst_b  (~reset),
    .s      (usr_s),
    .I      (usr_I),
    .MSB_in (usr_MSB_in),
    .LSB_in (usr_LSB_in),
    .Q      (usr_Q)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [N-1:0] data, input logic dir);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.b    = dir ? data[N-1-k] : data[k];
      e.last = (k == N - 1);
      sb.push_back(e);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock cycle: score the serial output, note any handshake, advance.
  task automatic step();
    logic acc;
    exp_t e;
    #1;
    acc = ser_valid;
`ifdef USR_CTRL_STALL_EN
    acc = acc && ser_ready;
`endif
    check("done", {7'd0, done}, {7'd0, exp_done});
    exp_done = 1'b0;
    if (acc) begin
      check("sb_nonempty", {7'd0, sb.size() != 0}, 8'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ser_bit", {7'd0, ser_bit}, {7'd0, e.b});
        if (e.last) exp_done = 1'b1;
      end
    end
    if (!reset && in_valid && in_ready) push_word(in_data, in_dir);
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset    = 1'b1;
    in_data  = '0;
    in_dir   = 1'b0;
    in_fill  = 1'b0;
    in_valid = 1'b1;
`ifdef USR_CTRL_STALL_EN
    ser_ready = 1'b1;
`endif
    @(posedge clk);
    #2;

    // Reset: outputs forced even with a request pending.
    settle();
    check("rst_usr_s", {6'd0, usr_s}, {6'd0, USR_HOLD});
    check("rst_in_ready", {7'd0, in_ready}, 8'd0);
    check("rst_ser_valid", {7'd0, ser_valid}, 8'd0);
    step();
    in_valid = 1'b0;
    reset    = 1'b0;
    settle();
    check("post_rst_in_ready", {7'd0, in_ready}, 8'd1);
    check("post_rst_ser_valid", {7'd0, ser_valid}, 8'd0);
    step();

    // LSB-first 1011, fill 0.
    in_data = 4'b1011; in_dir = 1'b0; in_fill = 1'b0; in_valid = 1'b1;
    settle();
    check("lsb_load_s", {6'd0, usr_s}, {6'd0, USR_LOAD});
    check("lsb_usr_I", {4'd0, usr_I}, 8'h0B);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      settle();
      check("lsb_ser_valid", {7'd0, ser_valid}, 8'd1);
      check("lsb_usr_s", {6'd0, usr_s}, {6'd0, USR_RIGHT});
      step();
    end
    settle();
    check("lsb_done_ready", {7'd0, in_ready}, 8'd1);
    check("lsb_q_after", {4'd0, usr_Q}, 8'h00);
    step();

    // MSB-first 1011, fill 1.
    in_data = 4'b1011; in_dir = 1'b1; in_fill = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_dir = 1'b0; in_fill = 1'b0; in_data = 4'h0;
    for (int i = 0; i < N; i++) begin
      settle();
      check("msb_usr_s", {6'd0, usr_s}, {6'd0, USR_LEFT});
      check("msb_fill_in", {7'd0, usr_LSB_in}, 8'd1);
      step();
    end
    settle();
    check("msb_q_after", {4'd0, usr_Q}, 8'h0F);
    step();

    // Back-to-back: in_valid held, A then 5.
    in_data = 4'hA; in_dir = 1'b0; in_fill = 1'b0; in_valid = 1'b1;
    step();
    in_data = 4'h5;
    for (int i = 0; i < N; i++) begin
      settle();
      check("b2b_in_ready_busy", {7'd0, in_ready}, 8'd0);
      step();
    end
    settle();
    check("b2b_done", {7'd0, done}, 8'd1);
    check("b2b_in_ready", {7'd0, in_ready}, 8'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) step();
    step();

    // Request during SHIFT is ignored.
    in_data = 4'b0110; in_dir = 1'b0; in_fill = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    in_data = 4'hF; in_valid = 1'b1; in_dir = 1'b1;
    settle();
    check("ign_in_ready", {7'd0, in_ready}, 8'd0);
    check("ign_usr_s", {6'd0, usr_s}, {6'd0, USR_RIGHT});
    step();
    in_valid = 1'b0;
    step();
    step();
    settle();
    check("ign_q_after", {4'd0, usr_Q}, 8'h0F);
    step();

    // Reset after two bits aborts the transfer.
    in_data = 4'b1011; in_dir = 1'b0; in_fill = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    sb.delete();
    settle();
    check("midrst_usr_s", {6'd0, usr_s}, {6'd0, USR_HOLD});
    check("midrst_ser_valid", {7'd0, ser_valid}, 8'd0);
    step();
    reset = 1'b0;
    settle();
    check("midrst_idle_ready", {7'd0, in_ready}, 8'd1);
    check("midrst_idle_valid", {7'd0, ser_valid}, 8'd0);
    step();
    in_data = 4'b1001; in_dir = 1'b1; in_fill = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) step();
    settle();
    check("midrst_q_after", {4'd0, usr_Q}, 8'h00);
    step();

`ifdef USR_CTRL_STALL_EN
    // Consumer stalls two cycles on bit 1.
    in_data = 4'b1011; in_dir = 1'b0; in_fill = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    ser_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("stall_bit_held", {7'd0, ser_bit}, 8'd1);
      check("stall_usr_s", {6'd0, usr_s}, {6'd0, USR_HOLD});
      check("stall_valid", {7'd0, ser_valid}, 8'd1);
      step();
    end
    ser_ready = 1'b1;
    for (int i = 0; i < N - 1; i++) step();
    step();
`endif

    check("sb_drained", sb.size() == 0 ? 8'd1 : 8'd0, 8'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
